// File: rtl/proc_pkg.sv
// Shared types for the simple processor controller: FSM state encoding,
// instruction opcodes and ALU operation selects.
package proc_pkg;

  // Encodings are exposed on the State port for display.
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/instr_decode.sv
// Combinational split of the instruction register into opcode and fields.
// Loads address memory with IR[11:4]; stores use IR[7:0].
module instr_decode #(
  parameter int IW = 16,
  parameter int DW = 8,
  parameter int RW = 4
) (
  input  logic [IW-1:0] ir,
  output logic [3:0]    op,
  output logic [RW-1:0] ra,
  output logic [RW-1:0] rb,
  output logic [RW-1:0] rw,
  output logic [DW-1:0] ld_addr,
  output logic [DW-1:0] st_addr
);

  assign op      = ir[IW-1 -: 4];
  assign ra      = ir[8 +: RW];
  assign rb      = ir[4 +: RW];
  assign rw      = ir[0 +: RW];
  assign ld_addr = ir[4 +: DW];
  assign st_addr = ir[0 +: DW];

endmodule

// File: rtl/control_unit.sv
// Moore controller for a small load/store processor: sequences fetch,
// decode and execute, driving PC, IR, data-memory, register-file and ALU.
module control_unit
  import proc_pkg::*;
#(
  parameter int IW = 16,
  parameter int DW = 8,
  parameter int RW = 4
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic [IW-1:0] IR,
  output logic          PC_Clr,
  output logic          PC_Up,
  output logic          IR_Ld,
  output logic [DW-1:0] D_Addr,
  output logic          D_Wr,
  output logic          RF_s,
  output logic [RW-1:0] RF_W_Addr,
  output logic          RF_W_En,
  output logic [RW-1:0] RF_Ra_Addr,
  output logic [RW-1:0] RF_Rb_Addr,
  output logic [2:0]    ALU_s0,
  output logic          Halted,
  output logic [3:0]    State
);

  state_t        state, state_next;
  logic [3:0]    op;
  logic [RW-1:0] ra, rb, rw;
  logic [DW-1:0] ld_addr, st_addr;

  instr_decode #(.IW(IW), .DW(DW), .RW(RW)) u_decode (
    .ir      (IR),
    .op      (op),
    .ra      (ra),
    .rb      (rb),
    .rw      (rw),
    .ld_addr (ld_addr),
    .st_addr (st_addr)
  );

  always_ff @(posedge Clk) begin
    if (!ResetN) state <= S_INIT;
    else         state <= state_next;
  end

  assign State = state;

  always_comb begin
    state_next = state;
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_En    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = ALU_PASS;
    Halted     = 1'b0;
    case (state)
      S_INIT: begin
        PC_Clr     = 1'b1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        IR_Ld      = 1'b1;
        PC_Up      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_STORE: state_next = S_STORE;
          OP_LOAD:  state_next = S_LOADA;
          OP_ADD:   state_next = S_ADD;
          OP_SUB:   state_next = S_SUB;
          OP_HALT:  state_next = S_HALT;
          default:  state_next = S_NOOP;
        endcase
      end
      S_NOOP: state_next = S_FETCH;
      // LoadA only presents the address; the write waits a cycle for read data.
      S_LOADA: begin
        D_Addr     = ld_addr;
        RF_s       = 1'b1;
        RF_W_Addr  = rw;
        state_next = S_LOADB;
      end
      S_LOADB: begin
        D_Addr     = ld_addr;
        RF_s       = 1'b1;
        RF_W_Addr  = rw;
        RF_W_En    = 1'b1;
        state_next = S_FETCH;
      end
      S_STORE: begin
        D_Addr     = st_addr;
        RF_Ra_Addr = ra;
        D_Wr       = 1'b1;
        state_next = S_FETCH;
      end
      S_ADD: begin
        RF_Ra_Addr = ra;
        RF_Rb_Addr = rb;
        RF_W_Addr  = rw;
        RF_W_En    = 1'b1;
        ALU_s0     = ALU_ADD;
        state_next = S_FETCH;
      end
      S_SUB: begin
        RF_Ra_Addr = ra;
        RF_Rb_Addr = rb;
        RF_W_Addr  = rw;
        RF_W_En    = 1'b1;
        ALU_s0     = ALU_SUB;
        state_next = S_FETCH;
      end
      S_HALT: begin
        Halted     = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_INIT;
    endcase
  end

endmodule
